pac_motion_ctrl: RTL
====================

// Module: pac_motion_ctrl
// PURPOSE
//  Tile-based Pacman motion sequencer. Paces movement with a divided tick and checks
//  walls through a req/ack handshake to the maze map. Drives pac_col/pac_row, the
//  one-hot direction and mouth phase consumed by the Pacman sprite ROM and renderer.
//  Sits between keyboard decode, maze map ROM and the sprite pixel path.
// PARAMETERS
//  TICK_DIV   1000000  clk cycles per movement tick (>=4)
//  ANIM_STEPS 4        successful moves per mouth_open toggle (>=1)
//  MAX_COL    27       last maze column (5-bit)
//  MAX_ROW    30       last maze row (5-bit)
//  START_COL  13       column after reset
//  START_ROW  23       row after reset
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous active-low reset
//  en         in   1  game running; low = no new moves
//  key_dir    in   4  requested direction, one-hot L=1000 U=0100 R=0010 D=0001
//  map_req    out  1  wall query valid
//  map_col    out  5  queried column
//  map_row    out  5  queried row
//  map_ack    in   1  query done; map_wall valid this cycle
//  map_wall   in   1  1 = queried tile is wall
//  pac_col    out  5  current column
//  pac_row    out  5  current row
//  direction  out  4  current heading, one-hot as key_dir
//  mouth_open out  1  animation phase to sprite ROM
//  step_done  out  1  1-cycle pulse per completed tick evaluation
// BEHAVIOUR
//  Reset: pac_col=START_COL, pac_row=START_ROW, direction=R(0010), mouth_open=0,
//   map_req=0, step_done=0, pend_dir=0, tick counter=0, FSM=WAIT.
//  Tick: counter 0..TICK_DIV-1 free-running; tick at TICK_DIV-1. Tick outside WAIT sets
//   tick_pend (max 1; further ticks dropped). Tick/tick_pend ignored while en=0 (cleared).
//  key_dir: latched into pend_dir only if exactly one bit set; 0000 or multi-hot ignored.
//   pend_dir held until accepted or overwritten by newer valid key.
//  FSM WAIT -> (tick|tick_pend)&en: if pend_dir!=0 -> CHK_NEW else CHK_CUR.
//   CHK_NEW: query neighbour in pend_dir; on ack: wall=0 -> direction<=pend_dir,
//    pend_dir<=0, MOVE; wall=1 -> CHK_CUR (pend_dir kept).
//   CHK_CUR: query neighbour in direction; ack: wall=0 -> MOVE; wall=1 -> DONE.
//   MOVE: update pac_col/pac_row by one tile (1 cycle); anim counter++; on reaching
//    ANIM_STEPS toggle mouth_open, counter<=0. -> DONE.
//   DONE: step_done=1 for one cycle -> WAIT.
//  Handshake: map_req asserted on state entry, map_col/map_row stable while map_req=1;
//   map_wall sampled only in ack cycle; map_req drops the cycle after ack. No timeout.
//  Out-of-range row (U from 0, D from MAX_ROW): treated as wall, no query issued.
//  Blocked: position, mouth_open unchanged; step_done still pulses.
//  en deasserted mid-query: query completes and result applied; no further ticks.
//  Reset mid-operation: everything returns to reset values immediately (async).
// CONFIGURATION
//  PAC_MOTION_TUNNEL_EN defined: L from col 0 queries/moves to MAX_COL, R from MAX_COL
//   to 0 (tunnel wrap). Undefined: those moves are walls, no query issued.
// STRUCTURE
//  Package pac_pkg: DIR_L/DIR_U/DIR_R/DIR_D one-hot constants, motion FSM state enum,
//   default MAX_COL/MAX_ROW. Sub-module pac_tick_gen (TICK_DIV divider, 1-cycle tick).
// TESTING
//  1 Reset, en=1, no key, map_wall=0, TICK_DIV=8 -> col 13->14 after first tick, direction=0010.
//  2 key_dir=0100 at (13,23), query (13,22) wall=0 -> row=22, direction=0100, pend cleared.
//  3 key_dir=1000, left tile wall, right free -> pend kept, query right, col+1, direction=0010.
//  4 Both neighbours wall -> no map change, step_done pulse, mouth_open unchanged.
//  5 At col 0 heading L, free: with TUNNEL_EN col->27; without no query, col stays 0.
//  6 map_ack delayed 20 cycles past 2 ticks -> addr stable, exactly one extra eval; rst_n low mid-query -> START pos, map_req=0.

Source files
------------

// File: rtl/pac_pkg.sv
// Shared definitions for the Pacman motion sequencer: headings, FSM states, maze bounds.
// PAC_MOTION_TUNNEL_EN defined: horizontal moves off either edge wrap to the other side.
package pac_pkg;

    localparam logic [3:0] DIR_L = 4'b1000;
    localparam logic [3:0] DIR_U = 4'b0100;
    localparam logic [3:0] DIR_R = 4'b0010;
    localparam logic [3:0] DIR_D = 4'b0001;

    localparam int PAC_MAX_COL = 27;
    localparam int PAC_MAX_ROW = 30;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_CHK_NEW,
        ST_CHK_CUR,
        ST_MOVE,
        ST_DONE
    } motion_st_e;

    // Neighbouring tile; ok=0 means off the maze, which counts as a wall without a query.
    typedef struct packed {
        logic       ok;
        logic [4:0] col;
        logic [4:0] row;
    } tile_t;

    function automatic logic onehot4(input logic [3:0] d);
        return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
    endfunction

    function automatic tile_t neighbour(input logic [4:0] col, input logic [4:0] row,
                                        input logic [3:0] dir,
                                        input logic [4:0] max_col, input logic [4:0] max_row);
        tile_t t;
        t.ok  = 1'b1;
        t.col = col;
        t.row = row;
        case (dir)
            DIR_L: begin
                if (col == 5'd0) begin
`ifdef PAC_MOTION_TUNNEL_EN
                    t.col = max_col;
`else
                    t.ok = 1'b0;
`endif
                end else begin
                    t.col = col - 5'd1;
                end
            end
            DIR_R: begin
                if (col == max_col) begin
`ifdef PAC_MOTION_TUNNEL_EN
                    t.col = 5'd0;
`else
                    t.ok = 1'b0;
`endif
                end else begin
                    t.col = col + 5'd1;
                end
            end
            DIR_U: begin
                if (row == 5'd0) t.ok = 1'b0;
                else             t.row = row - 5'd1;
            end
            DIR_D: begin
                if (row == max_row) t.ok = 1'b0;
                else                t.row = row + 5'd1;
            end
            default: t.ok = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pac_tick_gen.sv
// Free-running movement tick divider: one-cycle tick when the counter sits at TICK_DIV-1.
module pac_tick_gen #(
    parameter int TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/pac_motion_ctrl.sv
// Tile-based Pacman motion sequencer: paced by pac_tick_gen, wall checks via map req/ack.
// PAC_MOTION_TUNNEL_EN (see pac_pkg) enables the left/right tunnel wrap.
module pac_motion_ctrl
    import pac_pkg::*;
#(
    parameter int TICK_DIV   = 1000000,
    parameter int ANIM_STEPS = 4,
    parameter int MAX_COL    = PAC_MAX_COL,
    parameter int MAX_ROW    = PAC_MAX_ROW,
    parameter int START_COL  = 13,
    parameter int START_ROW  = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] key_dir,
    output logic       map_req,
    output logic [4:0] map_col,
    output logic [4:0] map_row,
    input  logic       map_ack,
    input  logic       map_wall,
    output logic [4:0] pac_col,
    output logic [4:0] pac_row,
    output logic [3:0] direction,
    output logic       mouth_open,
    output logic       step_done
);

    localparam logic [4:0]  MC        = 5'(MAX_COL);
    localparam logic [4:0]  MR        = 5'(MAX_ROW);
    localparam logic [4:0]  SC        = 5'(START_COL);
    localparam logic [4:0]  SR        = 5'(START_ROW);
    localparam logic [15:0] ANIM_LAST = 16'(ANIM_STEPS - 1);

    motion_st_e  st;
    logic        tick, tick_pend, trig;
    logic [3:0]  pend_dir, q_dir;
    logic [15:0] anim_cnt;
    tile_t       nb_new, nb_cur;

    pac_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign nb_new = neighbour(pac_col, pac_row, pend_dir, MC, MR);
    assign nb_cur = neighbour(pac_col, pac_row, direction, MC, MR);
    assign trig   = (tick | tick_pend) & en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= ST_WAIT;
            tick_pend  <= 1'b0;
            pend_dir   <= 4'd0;
            q_dir      <= 4'd0;
            anim_cnt   <= 16'd0;
            map_req    <= 1'b0;
            map_col    <= 5'd0;
            map_row    <= 5'd0;
            pac_col    <= SC;
            pac_row    <= SR;
            direction  <= DIR_R;
            mouth_open <= 1'b0;
            step_done  <= 1'b0;
        end else begin
            step_done <= 1'b0;
            if (!en)                         tick_pend <= 1'b0;
            else if (tick && st != ST_WAIT)  tick_pend <= 1'b1;

            case (st)
                ST_WAIT: if (trig) begin
                    tick_pend <= 1'b0;
                    if (pend_dir != 4'd0 && nb_new.ok) begin
                        st      <= ST_CHK_NEW;
                        q_dir   <= pend_dir;
                        map_req <= 1'b1;
                        map_col <= nb_new.col;
                        map_row <= nb_new.row;
                    end else if (nb_cur.ok) begin
                        st      <= ST_CHK_CUR;
                        map_req <= 1'b1;
                        map_col <= nb_cur.col;
                        map_row <= nb_cur.row;
                    end else begin
                        st        <= ST_DONE;
                        step_done <= 1'b1;
                    end
                end
                ST_CHK_NEW: if (map_ack) begin
                    map_req <= 1'b0;
                    if (!map_wall) begin
                        direction <= q_dir;
                        pend_dir  <= 4'd0;
                        st        <= ST_MOVE;
                    end else begin
                        st <= ST_CHK_CUR;
                    end
                end
                ST_CHK_CUR: begin
                    // Arriving from a blocked CHK_NEW, req is low for one cycle before relaunching.
                    if (!map_req) begin
                        if (nb_cur.ok) begin
                            map_req <= 1'b1;
                            map_col <= nb_cur.col;
                            map_row <= nb_cur.row;
                        end else begin
                            st        <= ST_DONE;
                            step_done <= 1'b1;
                        end
                    end else if (map_ack) begin
                        map_req <= 1'b0;
                        if (!map_wall) begin
                            st <= ST_MOVE;
                        end else begin
                            st        <= ST_DONE;
                            step_done <= 1'b1;
                        end
                    end
                end
                ST_MOVE: begin
                    pac_col   <= map_col;
                    pac_row   <= map_row;
                    st        <= ST_DONE;
                    step_done <= 1'b1;
                    if (anim_cnt == ANIM_LAST) begin
                        anim_cnt   <= 16'd0;
                        mouth_open <= ~mouth_open;
                    end else begin
                        anim_cnt <= anim_cnt + 16'd1;
                    end
                end
                ST_DONE: st <= ST_WAIT;
                default: st <= ST_WAIT;
            endcase

            // A fresh valid key overrides both the held key and an acceptance clear.
            if (onehot4(key_dir)) pend_dir <= key_dir;
        end
    end

endmodule
